// File: rtl/bram_pkg.sv
// Shared types and sizing helpers for the byte-enable BRAM client.
package bram_pkg;

  typedef enum logic {
    BRAM_OP_READ  = 1'b0,
    BRAM_OP_WRITE = 1'b1
  } bram_op_e;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_be_client_resp_fifo.sv
// Response buffer: synchronous FIFO with register-array storage, head entry
// presented directly from the registers, occupancy count output.
module resp_fifo
  import bram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  // Pop only a real entry; a push into a full buffer is taken only when the
  // head leaves in the same cycle.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != FULL) | do_pop);

  assign dout  = mem[rptr];
  assign valid = (count != '0);

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is data only; it needs no reset.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/bram_be_client.sv
// Valid/ready request front end for a single-port byte-enable BRAM. Reads are
// credited against the response buffer so the one-cycle RAM latency never
// overflows it; responses return in request order.
module bram_be_client
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  input  logic [BE_WIDTH-1:0]   REQ_BE,
  output logic                  RESP_VALID,
  input  logic                  RESP_READY,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DI,
  output logic [BE_WIDTH-1:0]   RAM_BE,
  output logic                  RAM_WE,
  output logic                  RAM_RE,
  input  logic [DATA_WIDTH-1:0] RAM_DO
);

  localparam int CW = cnt_width(RESP_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(RESP_DEPTH);

  logic          inflight;
  logic [CW-1:0] occ;
  logic [CW:0]   used;
  logic          fire;
  bram_op_e      op;

  // Credit: a read in flight already owns a buffer slot. Registers only.
  assign used      = {1'b0, occ} + {{CW{1'b0}}, inflight};
  assign REQ_READY = RST_N & (used < DEPTH_C);

  assign op   = REQ_WE ? BRAM_OP_WRITE : BRAM_OP_READ;
  assign fire = REQ_VALID & REQ_READY;

  assign RAM_ADDR = REQ_ADDR;
  assign RAM_DI   = REQ_DATA;
  assign RAM_BE   = REQ_BE;
  assign RAM_WE   = fire & (op == BRAM_OP_WRITE);
  assign RAM_RE   = fire & (op == BRAM_OP_READ);

  // Tracks the read whose RAM_DO lands in the next cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) inflight <= 1'b0;
    else        inflight <= RAM_RE;
  end

  resp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH),
    .CW    (CW)
  ) u_resp_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (inflight),
    .din   (RAM_DO),
    .pop   (RESP_VALID & RESP_READY),
    .dout  (RESP_DATA),
    .valid (RESP_VALID),
    .count (occ)
  );

endmodule

// File: tb/tb_bram_be_client.sv
// Directed bench for bram_be_client with a byte-enable RAM model.
module tb_bram_be_client;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ_VALID, REQ_READY, REQ_WE;
  logic [9:0]  REQ_ADDR;
  logic [31:0] REQ_DATA;
  logic [3:0]  REQ_BE;
  logic        RESP_VALID, RESP_READY;
  logic [31:0] RESP_DATA;
  logic [9:0]  RAM_ADDR;
  logic [31:0] RAM_DI;
  logic [3:0]  RAM_BE;
  logic        RAM_WE, RAM_RE;
  logic [31:0] RAM_DO;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  bram_be_client #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .BE_WIDTH(4), .RESP_DEPTH(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_BE(REQ_BE),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_DATA(RESP_DATA),
    .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_BE(RAM_BE),
    .RAM_WE(RAM_WE), .RAM_RE(RAM_RE), .RAM_DO(RAM_DO)
  );

  // RAM model: synchronous read, byte-enable write.
  logic [31:0] ram [1024];
  logic [31:0] ref_mem [1024];
  always @(posedge CLK) begin
    if (RAM_WE)
      for (int b = 0; b < 4; b++)
        if (RAM_BE[b]) ram[RAM_ADDR][b*8 +: 8] <= RAM_DI[b*8 +: 8];
    if (RAM_RE) RAM_DO <= ram[RAM_ADDR];
  end

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_req();
    REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_DATA = '0; REQ_BE = '0;
  endtask

  task automatic ref_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  initial begin
    int acc, got, a, ridx;
    logic [31:0] expq [$];

    for (int i = 0; i < 1024; i++) begin
      ram[i] = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    RAM_DO = '0;
    RESP_READY = 1'b1;
    idle_req();

    // ---- 1: reset holds outputs quiet even with a request offered
    RST_N = 1'b0;
    REQ_VALID = 1'b1;
    tick(); tick();
    chk("rst_req_ready", {31'b0, REQ_READY}, 0);
    chk("rst_ram_re", {31'b0, RAM_RE}, 0);
    chk("rst_resp_valid", {31'b0, RESP_VALID}, 0);
    idle_req();
    RST_N = 1'b1;
    tick(); tick(); tick();
    chk("idle_resp_valid", {31'b0, RESP_VALID}, 0);
    chk("idle_req_ready", {31'b0, REQ_READY}, 1);
    chk("idle_ram_we_re", {30'b0, RAM_WE, RAM_RE}, 0);

    // ---- 2/3 + extra: table of write/read vectors, hand-computed results
    tbl[0] = '{1'b1, 10'd5,    32'hDEAD_BEEF, 4'hF,    32'h0};
    tbl[1] = '{1'b0, 10'd5,    32'h0,         4'h0,    32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 10'd5,    32'h0000_AA00, 4'b0010, 32'h0};
    tbl[3] = '{1'b0, 10'd5,    32'h0,         4'h0,    32'hDEAD_AAEF};
    tbl[4] = '{1'b1, 10'd7,    32'h1122_3344, 4'b1001, 32'h0};
    tbl[5] = '{1'b0, 10'd7,    32'h0,         4'h0,    32'h1100_0044};
    tbl[6] = '{1'b0, 10'd3,    32'h0,         4'h0,    32'hA500_0003};
    tbl[7] = '{1'b1, 10'd1023, 32'hFFFF_FFFF, 4'h0,    32'h0};
    tbl[8] = '{1'b0, 10'd1023, 32'h0,         4'h0,    32'hA500_03FF};
    tbl[9] = '{1'b0, 10'd0,    32'h0,         4'h0,    32'hA500_0000};

    for (int i = 0; i < 10; i++) begin
      REQ_VALID = 1'b1; REQ_WE = tbl[i].we; REQ_ADDR = tbl[i].addr;
      REQ_DATA = tbl[i].data; REQ_BE = tbl[i].be;
      #1;
      chk($sformatf("v%0d_req_ready", i), {31'b0, REQ_READY}, 1);
      chk($sformatf("v%0d_we_re", i), {30'b0, RAM_WE, RAM_RE}, tbl[i].we ? 32'd2 : 32'd1);
      chk($sformatf("v%0d_ram_be", i), {28'b0, RAM_BE}, {28'b0, tbl[i].be});
      if (tbl[i].we) ref_write(tbl[i].addr, tbl[i].data, tbl[i].be);
      tick();
      idle_req();
      if (!tbl[i].we) begin
        chk($sformatf("v%0d_n1_valid", i), {31'b0, RESP_VALID}, 0);
        tick();
        chk($sformatf("v%0d_n2_valid", i), {31'b0, RESP_VALID}, 1);
        chk($sformatf("v%0d_n2_data", i), RESP_DATA, tbl[i].exp);
      end
    end
    tick();
    chk("tbl_drained", {31'b0, RESP_VALID}, 0);

    // ---- 4: back-pressure; credit stops at 4 outstanding reads
    RESP_READY = 1'b0;
    acc = 0; a = 0;
    for (int c = 0; c < 8; c++) begin
      REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = a[9:0];
      #1;
      if (REQ_READY) begin acc++; expq.push_back(ref_mem[a]); a++; end
      if (RESP_VALID) chk("bp_head_stable", RESP_DATA, ref_mem[0]);
      tick();
    end
    chk("bp_accepted", acc, 4);
    chk("bp_req_ready_low", {31'b0, REQ_READY}, 0);
    chk("bp_resp_valid", {31'b0, RESP_VALID}, 1);
    RESP_READY = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      REQ_VALID = (a < 6); REQ_ADDR = a[9:0];
      #1;
      if (RESP_VALID) begin
        chk($sformatf("bp_resp%0d", got), RESP_DATA, expq.pop_front());
        got++;
      end
      if (REQ_VALID && REQ_READY) begin expq.push_back(ref_mem[a]); a++; end
      tick();
    end
    idle_req();
    chk("bp_resp_count", got, 6);
    tick();

    // ---- 5: streaming, one read per cycle, responses at c+2
    ridx = 0;
    for (int c = 0; c < 20; c++) begin
      REQ_VALID = (c < 16); REQ_WE = 1'b0; REQ_ADDR = 10'(c);
      #1;
      if (c < 16) chk($sformatf("st_ready%0d", c), {31'b0, REQ_READY}, 1);
      if (RESP_VALID) begin
        chk($sformatf("st_cycle%0d", ridx), c, ridx + 2);
        chk($sformatf("st_data%0d", ridx), RESP_DATA, ref_mem[ridx]);
        ridx++;
      end
      tick();
    end
    idle_req();
    chk("st_resp_count", ridx, 16);

    // ---- 6: reset with one read in flight and two buffered
    RESP_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 10'(c);
      tick();
    end
    idle_req();
    #1;
    chk("mr_pre_valid", {31'b0, RESP_VALID}, 1);
    chk("mr_pre_ready", {31'b0, REQ_READY}, 1);
    RST_N = 1'b0;
    REQ_VALID = 1'b1;
    #1;
    chk("mr_rst_ram_re", {31'b0, RAM_RE}, 0);
    chk("mr_rst_ready", {31'b0, REQ_READY}, 0);
    tick();
    idle_req();
    RST_N = 1'b1;
    RESP_READY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("mr_valid%0d", c), {31'b0, RESP_VALID}, 0);
      chk($sformatf("mr_ready%0d", c), {31'b0, REQ_READY}, 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
